// File: rtl/ext_int_claim_arbiter.sv
// ext_int_claim_arbiter
// Priority external-interrupt arbiter sitting between level IRQ lines and the
// core's machine external interrupt input. Each source has a gateway that
// latches a pending bit. The highest-priority pending source above THRESHOLD is
// offered to the core. A single-outstanding claim/complete handshake sequences
// service.
//
// Bus fields are packed into flat vectors:
//   sys_share = {waddr[31:0], raddr[31:0], wdata[31:0]}
//   sel       = {wen, ren}
// Register offsets are decoded on the full address. Any address other than the
// six word offsets 0x00..0x14 is unmapped.
module ext_int_claim_arbiter #(
   parameter int INT_NUM           = 8,
   parameter int PRIO_W            = 3,
   parameter int CUSTOM_CODE_BEGIN = 16
) (
   input  logic               hb_clk,
   input  logic               rst_sync,
   input  logic [95:0]        sys_share,
   input  logic [1:0]         sel,
   output logic [31:0]        rdata,
   input  logic [INT_NUM-1:0] irq_source,
   output logic [30:0]        custom_int_code,
   output logic               mextern_int
);

   localparam int IDX_W = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

   localparam logic [2:0] R_ENABLE  = 3'd0;
   localparam logic [2:0] R_PENDING = 3'd1;
   localparam logic [2:0] R_THRESH  = 3'd2;
   localparam logic [2:0] R_CLAIM   = 3'd3;
   localparam logic [2:0] R_PRIO    = 3'd4;
   localparam logic [2:0] R_INSERV  = 3'd5;

   typedef enum logic {S_IDLE = 1'b0, S_CLAIMED = 1'b1} state_t;

   logic [31:0] waddr;
   logic [31:0] raddr;
   logic [31:0] wdata;
   logic        wen;
   logic        ren;

   assign waddr = sys_share[95:64];
   assign raddr = sys_share[63:32];
   assign wdata = sys_share[31:0];
   assign wen   = sel[1];
   assign ren   = sel[0];

   // Word-aligned offset inside the 0x00..0x14 window.
   function automatic logic addr_mapped(input logic [31:0] a);
      return (a[31:5] == 27'd0) && (a[1:0] == 2'b00) && (a[4:2] <= R_INSERV);
   endfunction

   logic wr_enable, wr_thresh, wr_claim, wr_prio, rd_claim;

   assign wr_enable = wen && addr_mapped(waddr) && (waddr[4:2] == R_ENABLE);
   assign wr_thresh = wen && addr_mapped(waddr) && (waddr[4:2] == R_THRESH);
   assign wr_claim  = wen && addr_mapped(waddr) && (waddr[4:2] == R_CLAIM);
   assign wr_prio   = wen && addr_mapped(waddr) && (waddr[4:2] == R_PRIO);
   assign rd_claim  = ren && addr_mapped(raddr) && (raddr[4:2] == R_CLAIM);

   state_t             state_q, state_d;
   logic [INT_NUM-1:0] enable_q, enable_d;
   logic [INT_NUM-1:0] pending_q, pending_d;
   logic [INT_NUM-1:0] in_service_q, in_service_d;
   logic [PRIO_W-1:0]  prio_q [INT_NUM];
   logic [PRIO_W-1:0]  prio_d [INT_NUM];
   logic [PRIO_W-1:0]  threshold_q, threshold_d;
   logic [IDX_W-1:0]   best_idx_q, best_idx_d;
   logic [PRIO_W-1:0]  best_prio_q, best_prio_d;
   logic [IDX_W-1:0]   claimed_idx_q, claimed_idx_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [30:0]        custom_int_code_q, custom_int_code_d;
   logic               mextern_int_q, mextern_int_d;
   logic [31:0]        prio_rd;
   logic               claim_ok, complete_ok;

   // A claim only succeeds from IDLE against the registered winner snapshot.
   // A complete only counts when it names the ID that was handed out.
   assign claim_ok    = rd_claim && (state_q == S_IDLE) && (best_prio_q > threshold_q);
   assign complete_ok = wr_claim && (state_q == S_CLAIMED)
                        && (wdata == (32'(claimed_idx_q) + 32'd1));

   // Arbiter: max priority among pending sources; strict '>' keeps the lowest index on ties.
   always_comb begin
      best_idx_d  = '0;
      best_prio_d = '0;
      for (int i = 0; i < INT_NUM; i++) begin
         if (pending_q[i] && (prio_q[i] > best_prio_d)) begin
            best_idx_d  = IDX_W'(i);
            best_prio_d = prio_q[i];
         end
      end
   end

   // FSM next state: claim enters CLAIMED, matching complete returns to IDLE.
   always_comb begin
      state_d = state_q;
      if (state_q == S_IDLE) begin
         if (claim_ok) state_d = S_CLAIMED;
      end else begin
         if (complete_ok) state_d = S_IDLE;
      end
   end

   // FSM outputs: interrupt request and cause code are held at 0 while a claim is outstanding.
   always_comb begin
      mextern_int_d     = (state_d == S_IDLE) && (best_prio_d > threshold_q);
      custom_int_code_d = '0;
      if (mextern_int_d) custom_int_code_d = 31'(CUSTOM_CODE_BEGIN) + 31'(best_idx_d);
   end

   // Gateways, in-service tracking and programmable registers.
   always_comb begin
      enable_d      = enable_q;
      threshold_d   = threshold_q;
      prio_d        = prio_q;
      pending_d     = pending_q;
      in_service_d  = in_service_q;
      claimed_idx_d = claimed_idx_q;
      if (wr_enable) enable_d = wdata[INT_NUM-1:0];
      if (wr_thresh) threshold_d = wdata[PRIO_W-1:0];
      if (wr_prio) begin
         for (int i = 0; i < INT_NUM; i++) prio_d[i] = wdata[4*i +: PRIO_W];
      end
      for (int i = 0; i < INT_NUM; i++) begin
         if (irq_source[i] && enable_q[i] && !in_service_q[i] && !pending_q[i]) pending_d[i] = 1'b1;
         if (wr_enable && !wdata[i]) pending_d[i] = 1'b0;
      end
      if (claim_ok) begin
         pending_d[best_idx_q]    = 1'b0;
         in_service_d[best_idx_q] = 1'b1;
         claimed_idx_d            = best_idx_q;
      end
      if (complete_ok) in_service_d[claimed_idx_q] = 1'b0;
   end

   // Priority register readback image, one nibble per source.
   always_comb begin
      prio_rd = '0;
      for (int i = 0; i < INT_NUM; i++) prio_rd[4*i +: 4] = 4'(prio_q[i]);
   end

   // Read mux: capture on ren, hold otherwise.
   always_comb begin
      rdata_d = rdata_q;
      if (ren) begin
         rdata_d = 32'd0;
         if (addr_mapped(raddr)) begin
            case (raddr[4:2])
               R_ENABLE:  rdata_d = 32'(enable_q);
               R_PENDING: rdata_d = 32'(pending_q);
               R_THRESH:  rdata_d = 32'(threshold_q);
               R_CLAIM:   rdata_d = claim_ok ? (32'(best_idx_q) + 32'd1) : 32'd0;
               R_PRIO:    rdata_d = prio_rd;
               R_INSERV:  rdata_d = 32'(in_service_q);
               default:   rdata_d = 32'd0;
            endcase
         end
      end
   end

   // FSM state register.
   always_ff @(posedge hb_clk) begin
      if (rst_sync) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Datapath and control registers.
   always_ff @(posedge hb_clk) begin
      if (rst_sync) begin
         enable_q          <= '0;
         pending_q         <= '0;
         in_service_q      <= '0;
         threshold_q       <= '0;
         best_idx_q        <= '0;
         best_prio_q       <= '0;
         claimed_idx_q     <= '0;
         rdata_q           <= '0;
         custom_int_code_q <= '0;
         mextern_int_q     <= 1'b0;
         for (int i = 0; i < INT_NUM; i++) prio_q[i] <= '0;
      end else begin
         enable_q          <= enable_d;
         pending_q         <= pending_d;
         in_service_q      <= in_service_d;
         threshold_q       <= threshold_d;
         best_idx_q        <= best_idx_d;
         best_prio_q       <= best_prio_d;
         claimed_idx_q     <= claimed_idx_d;
         rdata_q           <= rdata_d;
         custom_int_code_q <= custom_int_code_d;
         mextern_int_q     <= mextern_int_d;
         for (int i = 0; i < INT_NUM; i++) prio_q[i] <= prio_d[i];
      end
   end

   assign rdata           = rdata_q;
   assign custom_int_code = custom_int_code_q;
   assign mextern_int     = mextern_int_q;

endmodule
